// File: rtl/lc3_decode_stage_elastic.sv
// LC3 decode stage with valid/ready handshake, optional skid buffer and flush.
// Decodes in_ir at the input and registers the decoded entry toward execute.
module lc3_decode_stage_elastic #(
    parameter int unsigned NPC_W   = 16,
    parameter bit          ELASTIC = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_ir,
    input  logic [NPC_W-1:0] in_npc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       e_control,
    output logic             mem_control,
    output logic [1:0]       w_control,
    output logic [15:0]      ir,
    output logic [NPC_W-1:0] npc_out,
    output logic             illegal
);

    typedef struct packed {
        logic [5:0]       e;
        logic             mem;
        logic [1:0]       w;
        logic             ill;
        logic [15:0]      ir;
        logic [NPC_W-1:0] npc;
    } entry_t;

    entry_t dec;
    entry_t main_q;
    logic   main_v;
    logic   alive;

    // e layout: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    always_comb begin
        dec     = '0;
        dec.ir  = in_ir;
        dec.npc = in_npc;
        case (in_ir[15:12])
            4'b0001: dec.e[0] = ~in_ir[5];
            4'b0101: begin
                dec.e[5:4] = 2'b01;
                dec.e[0]   = ~in_ir[5];
            end
            4'b1001: dec.e[5:4] = 2'b10;
            4'b0000,
            4'b0011: dec.e[3:1] = 3'b011;
            4'b1100: dec.e[3:2] = 2'b11;
            4'b0010: begin
                dec.e[3:1] = 3'b011;
                dec.w      = 2'b10;
            end
            4'b0110: begin
                dec.e[3:2] = 2'b10;
                dec.w      = 2'b10;
            end
            4'b1010: begin
                dec.e[3:1] = 3'b011;
                dec.w      = 2'b10;
                dec.mem    = 1'b1;
            end
            4'b1110: begin
                dec.e[3:1] = 3'b011;
                dec.w      = 2'b01;
            end
            4'b0111: dec.e[3:2] = 2'b10;
            4'b1011: begin
                dec.e[3:1] = 3'b011;
                dec.mem    = 1'b1;
            end
            default: dec.ill = 1'b1;
        endcase
    end

    // Holds in_ready low while reset is asserted and releases it one edge later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) alive <= 1'b0;
        else       alive <= 1'b1;
    end

    generate
        if (ELASTIC) begin : g_elastic
            entry_t skid_q;
            logic   skid_v;
            logic   accept;
            logic   drain;

            assign in_ready = alive & ~skid_v;
            assign accept   = in_valid & in_ready & ~flush;
            assign drain    = main_v & out_ready;

            // Skid only fills while main is occupied, so it always holds the younger entry.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    main_q <= '0;
                    main_v <= 1'b0;
                    skid_q <= '0;
                    skid_v <= 1'b0;
                end else if (flush) begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end else if (!main_v || drain) begin
                    if (skid_v) begin
                        main_q <= skid_q;
                        main_v <= 1'b1;
                        skid_v <= accept;
                        if (accept) skid_q <= dec;
                    end else begin
                        main_v <= accept;
                        if (accept) main_q <= dec;
                    end
                end else if (accept) begin
                    skid_q <= dec;
                    skid_v <= 1'b1;
                end
            end
        end else begin : g_single
            logic accept;

            assign in_ready = alive & (~main_v | out_ready);
            assign accept   = in_valid & in_ready & ~flush;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    main_q <= '0;
                    main_v <= 1'b0;
                end else if (flush) begin
                    main_v <= 1'b0;
                end else if (accept) begin
                    main_q <= dec;
                    main_v <= 1'b1;
                end else if (out_ready) begin
                    main_v <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid   = main_v;
    assign e_control   = main_q.e;
    assign mem_control = main_q.mem;
    assign w_control   = main_q.w;
    assign illegal     = main_q.ill;
    assign ir          = main_q.ir;
    assign npc_out     = main_q.npc;

endmodule

// File: tb/tb_lc3_decode_stage_elastic.sv
// Bench for lc3_decode_stage_elastic: an ELASTIC=1/NPC_W=16 and an ELASTIC=0/NPC_W=32
// instance share clock, reset, flush and instruction stream, each tracked by an entry queue.
module tb_lc3_decode_stage_elastic;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_ir, a_in_npc, a_ir, a_npc;
    logic [5:0]  a_e;
    logic        a_mem, a_ill;
    logic [1:0]  a_w;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_ir, b_ir;
    logic [31:0] b_in_npc, b_npc;
    logic [5:0]  b_e;
    logic        b_mem, b_ill;
    logic [1:0]  b_w;

    int checks   = 0;
    int failures = 0;

    logic [15:0] qa_ir[$];
    logic [15:0] qa_npc[$];
    logic [15:0] qb_ir[$];
    logic [31:0] qb_npc[$];
    logic        alive_m;

    always #5 clock = ~clock;

    lc3_decode_stage_elastic #(.NPC_W(16), .ELASTIC(1'b1)) dut_a (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ir(a_in_ir), .in_npc(a_in_npc),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .e_control(a_e), .mem_control(a_mem), .w_control(a_w),
        .ir(a_ir), .npc_out(a_npc), .illegal(a_ill)
    );

    lc3_decode_stage_elastic #(.NPC_W(32), .ELASTIC(1'b0)) dut_b (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ir(b_in_ir), .in_npc(b_in_npc),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .e_control(b_e), .mem_control(b_mem), .w_control(b_w),
        .ir(b_ir), .npc_out(b_npc), .illegal(b_ill)
    );

    // Expected {e_control, w_control, mem_control, illegal} from the opcode table.
    function automatic logic [9:0] exp_ctl(input logic [15:0] i);
        case (i[15:12])
            4'h1:    return {(i[5] ? 6'h00 : 6'h01), 2'b00, 1'b0, 1'b0};
            4'h5:    return {(i[5] ? 6'h10 : 6'h11), 2'b00, 1'b0, 1'b0};
            4'h9:    return {6'h20, 2'b00, 1'b0, 1'b0};
            4'h0:    return {6'h06, 2'b00, 1'b0, 1'b0};
            4'hC:    return {6'h0C, 2'b00, 1'b0, 1'b0};
            4'h2:    return {6'h06, 2'b10, 1'b0, 1'b0};
            4'h6:    return {6'h08, 2'b10, 1'b0, 1'b0};
            4'hA:    return {6'h06, 2'b10, 1'b1, 1'b0};
            4'hE:    return {6'h06, 2'b01, 1'b0, 1'b0};
            4'h3:    return {6'h06, 2'b00, 1'b0, 1'b0};
            4'h7:    return {6'h08, 2'b00, 1'b0, 1'b0};
            4'hB:    return {6'h06, 2'b00, 1'b1, 1'b0};
            default: return {6'h00, 2'b00, 1'b0, 1'b1};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        logic [9:0] c;
        chk("a_in_ready", a_in_ready, alive_m && (qa_ir.size() < 2));
        chk("a_out_valid", a_out_valid, qa_ir.size() != 0);
        if (qa_ir.size() != 0) begin
            c = exp_ctl(qa_ir[0]);
            chk("a_e_control", a_e, c[9:4]);
            chk("a_w_control", a_w, c[3:2]);
            chk("a_mem_control", a_mem, c[1]);
            chk("a_illegal", a_ill, c[0]);
            chk("a_ir", a_ir, qa_ir[0]);
            chk("a_npc_out", a_npc, qa_npc[0]);
        end
    endtask

    task automatic check_b();
        logic [9:0] c;
        chk("b_in_ready", b_in_ready, alive_m && (qb_ir.size() == 0 || b_out_ready));
        chk("b_out_valid", b_out_valid, qb_ir.size() != 0);
        if (qb_ir.size() != 0) begin
            c = exp_ctl(qb_ir[0]);
            chk("b_e_control", b_e, c[9:4]);
            chk("b_w_control", b_w, c[3:2]);
            chk("b_mem_control", b_mem, c[1]);
            chk("b_illegal", b_ill, c[0]);
            chk("b_ir", b_ir, qb_ir[0]);
            chk("b_npc_out", b_npc, qb_npc[0]);
        end
    endtask

    task automatic check_zero(input string ph);
        chk({ph, "_a_in_ready"}, a_in_ready, 1'b0);
        chk({ph, "_a_out_valid"}, a_out_valid, 1'b0);
        chk({ph, "_a_data"}, {a_e, a_w, a_mem, a_ill, a_ir, a_npc}, 64'h0);
        chk({ph, "_b_in_ready"}, b_in_ready, 1'b0);
        chk({ph, "_b_out_valid"}, b_out_valid, 1'b0);
        chk({ph, "_b_data"}, {b_e, b_w, b_mem, b_ill, b_ir, b_npc}, 64'h0);
    endtask

    // Called at posedge+1 with inputs already applied; checks, then advances the model one edge.
    task automatic tick();
        bit acc_a, acc_b, drn_a, drn_b;
        #2;
        check_a();
        check_b();
        acc_a = a_in_valid && alive_m && (qa_ir.size() < 2) && !flush;
        acc_b = b_in_valid && alive_m && (qb_ir.size() == 0 || b_out_ready) && !flush;
        drn_a = (qa_ir.size() != 0) && a_out_ready;
        drn_b = (qb_ir.size() != 0) && b_out_ready;
        @(posedge clock);
        if (!reset) begin
            if (flush) begin
                qa_ir.delete(); qa_npc.delete(); qb_ir.delete(); qb_npc.delete();
            end else begin
                if (drn_a) begin void'(qa_ir.pop_front()); void'(qa_npc.pop_front()); end
                if (drn_b) begin void'(qb_ir.pop_front()); void'(qb_npc.pop_front()); end
                if (acc_a) begin qa_ir.push_back(a_in_ir); qa_npc.push_back(a_in_npc); end
                if (acc_b) begin qb_ir.push_back(b_in_ir); qb_npc.push_back(b_in_npc); end
            end
            alive_m = 1'b1;
        end
        #1;
    endtask

    task automatic send(input logic v, input logic [15:0] i, input logic [31:0] n,
                        input logic ora, input logic orb);
        a_in_valid  = v;
        b_in_valid  = v;
        a_in_ir     = i;
        b_in_ir     = i;
        a_in_npc    = n[15:0];
        b_in_npc    = n;
        a_out_ready = ora;
        b_out_ready = orb;
        tick();
    endtask

    task automatic clear_model();
        qa_ir.delete(); qa_npc.delete(); qb_ir.delete(); qb_npc.delete();
        alive_m = 1'b0;
    endtask

    initial begin
        logic [15:0] stream [4];
        stream = '{16'h1265, 16'h927F, 16'hE3F0, 16'hA201};

        reset = 1'b1; flush = 1'b0;
        a_in_valid = 1'b0; a_in_ir = '0; a_in_npc = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_ir = '0; b_in_npc = '0; b_out_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clock);
        #3;
        check_zero("reset");
        reset = 1'b0;
        #1;

        send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);
        send(1'b1, 16'h1283, 32'h3001, 1'b1, 1'b1);
        send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);

        for (int k = 0; k < 4; k++) send(1'b1, stream[k], 32'h4000 + k, 1'b1, 1'b1);
        send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);
        send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);

        // Back-pressure: elastic instance takes two, single-register instance takes one.
        send(1'b1, 16'h2401, 32'h5000, 1'b0, 1'b0);
        send(1'b1, 16'h6A85, 32'h5001, 1'b0, 1'b0);
        send(1'b1, 16'h7C3F, 32'h5002, 1'b0, 1'b0);
        send(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);

        send(1'b1, 16'hB1FF, 32'h6000, 1'b0, 1'b0);
        send(1'b1, 16'hC1C0, 32'h6001, 1'b0, 1'b0);
        flush = 1'b1;
        send(1'b1, 16'h0E05, 32'h6002, 1'b0, 1'b0);
        flush = 1'b0;
        for (int k = 0; k < 3; k++) send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);

        send(1'b1, 16'hD000, 32'h7000, 1'b0, 1'b0);
        send(1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
        send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);

        for (int k = 0; k < 400; k++) begin
            flush = ($urandom_range(0, 39) == 0);
            send(($urandom_range(0, 3) != 0), 16'($urandom), $urandom,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
        end
        flush = 1'b0;

        // Asynchronous reset between edges while both instances hold a valid entry.
        send(1'b1, 16'h1283, 32'hDEAD_8001, 1'b0, 1'b0);
        send(1'b1, 16'h5020, 32'hBEEF_8002, 1'b0, 1'b0);
        #2;
        chk("pre_reset_a_valid", a_out_valid, 1'b1);
        chk("pre_reset_b_valid", b_out_valid, 1'b1);
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        clear_model();
        @(posedge clock);
        #3;
        check_zero("async_reset_held");
        reset = 1'b0;
        #1;
        send(1'b1, 16'h5020, 32'hCAFE_9001, 1'b1, 1'b1);
        send(1'b1, 16'h5020, 32'hCAFE_9001, 1'b1, 1'b1);
        send(1'b1, 16'h6A85, 32'hCAFE_9002, 1'b1, 1'b1);
        send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);
        send(1'b0, 16'h0000, 32'h0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_decode_stage_elastic.md
Name: lc3_decode_stage_elastic

Overview:
Parametrised successor of the LC3 decode stage that drives the decode_out bus (e_control, mem_control, w_control, ir, npc_out).
- Adds a valid/ready handshake on both sides, an optional 2-entry skid buffer (ELASTIC), a synchronous flush, configurable NPC width, and an illegal-opcode flag.
- Sits between fetch and execute.
- Existing decode_out agents monitor its outputs unchanged.

Parameters:
- NPC_W, 16, width of in_npc / npc_out.
- ELASTIC, 1, 1 = main register plus skid register (full-throughput, registered in_ready); 0 = single register (in_ready combinational).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- flush  input  1  synchronous; discards all held entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept.
- in_ir  input  16  instruction word.
- in_npc  input  NPC_W  next PC for that instruction.
- out_valid  output  1  decode_out entry valid.
- out_ready  input  1  execute accepts the entry.
- e_control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- mem_control  output  1  1 = indirect memory access (LDI/STI).
- w_control  output  2  writeback select: 00 ALU, 01 LEA/PC, 10 memory.
- ir  output  16  registered instruction.
- npc_out  output  NPC_W  registered NPC.
- illegal  output  1  unsupported opcode.

Behaviour:
Reset
- Asynchronous, active-high.
- While reset is high: out_valid=0, all data outputs 0, illegal=0, skid empty, in_ready=0.
- in_ready rises in the first cycle after reset deasserts.

Decode (combinational on in_ir[15:12]; values are {e_control hex, w_control, mem_control})
- ADD/AND/NOT: alu_control 00/01/10, op2select = ~in_ir[5] (NOT: 0).
  - ADD reg 0x01; ADD imm 0x00; AND reg 0x11; AND imm 0x10; NOT 0x20; all w=00, mem=0.
- BR 0000: 0x06, w=00, mem=0.
- JMP 1100: 0x0C, w=00, mem=0.
- LD 0010: 0x06, w=10, mem=0.
- LDR 0110: 0x08, w=10, mem=0.
- LDI 1010: 0x06, w=10, mem=1.
- LEA 1110: 0x06, w=01, mem=0.
- ST 0011: 0x06, w=00, mem=0.
- STR 0111: 0x08, w=00, mem=0.
- STI 1011: 0x06, w=00, mem=1.
- Any other opcode: controls all 0, illegal=1. ir and npc_out still pass through.

Handshake
- Accept when in_valid && in_ready.
- Accepted entry appears on outputs the next cycle (latency 1).
- Transfer out when out_valid && out_ready.
- While out_valid && !out_ready, all outputs hold stable.

ELASTIC=1
- in_ready = !skid_full, registered.
- If an accept occurs while main is valid and not draining, the entry goes to skid.
- When main drains with skid full, skid moves to main in the same edge.
- With an accept in that same edge, the new entry goes to skid.
- Sustained 1 transfer/cycle with out_ready=1.

ELASTIC=0
- in_ready = !out_valid || out_ready.

Flush
- At the edge where flush=1: main and skid are emptied; out_valid=0 next cycle.
- in_valid is ignored in the flush cycle.
- Flush has priority over accept and transfer.

Reset mid-operation
- Entries are lost immediately; no partial outputs.

Test Plan:
- Reset then in_ir=0x1283 (ADD R1,R2,R3), in_npc=0x3001 -> next cycle: out_valid=1, e_control=0x01, w_control=00, mem_control=0, ir=0x1283, npc_out=0x3001.
- Stream 0x1265, 0x927F, 0xE3F0, 0xA201 with out_ready=1 -> back-to-back outputs:
  - e_control 0x00, 0x20, 0x06, 0x06
  - w_control 00, 00, 01, 10
  - mem_control 1 only on 0xA201
  - in_ready stays 1
- ELASTIC=1, out_ready=0, three valid inputs -> two accepted, then in_ready=0. Outputs hold the first entry. After out_ready=1, entries emerge in order with no loss or duplication.
- Assert flush with main and skid full -> out_valid=0 next cycle, in_ready=1, and no flushed entry ever appears.
- in_ir=0xD000 -> illegal=1, e_control=0x00, w_control=00, mem_control=0, ir=0xD000.
- Assert reset asynchronously between edges while out_valid=1 -> outputs go 0 immediately. After release, the first accepted instruction decodes correctly. Repeat with ELASTIC=0 and NPC_W=32.
